// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state type and widths for the memory port arbiter
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GNT_D = 2'd1, GNT_I = 2'd2} arb_state_t;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int STREAK_W = 4;
  localparam int TMO_W = 8;
endpackage

// File: rtl/arb_watchdog.sv
// arb_watchdog: counts unacknowledged grant cycles and flags expiry at TIMEOUT-1
module arb_watchdog
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic expired
);
  logic [TMO_W-1:0] cnt;
  always_ff @(posedge clock or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= clr ? '0 : en ? cnt + 1'b1 : cnt;
  assign expired = en & (cnt == TMO_W'(TIMEOUT - 1));
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data access
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ready,
  input  logic                  dm_read,
  input  logic                  dm_write,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_ready,
  output logic                  stall_if,
  output logic                  stall_dm,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  bus_err
);
  arb_state_t state, nxt;
  logic [STREAK_W-1:0] streak, streak_nxt;
  logic granted, tmo, done, dm_any, pick_d;
  assign granted = state != IDLE;
  assign done = granted & (mem_ack | tmo);
  assign dm_any = dm_read | dm_write;
  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clock(clock), .reset(reset), .en(granted & ~mem_ack), .clr(~granted | done), .expired(tmo)
  );
  always_comb begin
    streak_nxt = (~if_req | (done & (state == GNT_I))) ? '0 :
                 (done & (state == GNT_D) & (streak != STREAK_W'(MAX_D_STREAK))) ? streak + 1'b1 : streak;
    pick_d = dm_any & ~(if_req & (streak_nxt == STREAK_W'(MAX_D_STREAK)));
    nxt = (granted & ~done) ? state : pick_d ? GNT_D : if_req ? GNT_I : IDLE;
  end
  assign if_ready = (state == GNT_I) & (mem_ack | tmo);
  assign dm_ready = (state == GNT_D) & (mem_ack | tmo);
  assign if_rdata = tmo ? '0 : mem_rdata;
  assign dm_rdata = tmo ? '0 : mem_rdata;
  assign stall_if = if_req & ~if_ready;
  assign stall_dm = dm_any & ~dm_ready;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      streak <= '0;
      bus_err <= 1'b0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      state <= nxt;
      streak <= streak_nxt;
      bus_err <= bus_err | tmo;
      if (~granted | done) begin
        mem_req <= nxt != IDLE;
        mem_we <= (nxt == GNT_D) ? dm_write : (nxt == GNT_I) ? 1'b0 : mem_we;
        mem_addr <= (nxt == GNT_D) ? dm_addr : (nxt == GNT_I) ? if_addr : mem_addr;
        mem_wdata <= (nxt == GNT_D) ? dm_wdata : mem_wdata;
      end
    end
endmodule
